// File: rtl/modaddsub_pkg.sv
// Shared types, state encodings and elaboration helpers for the serial modular adder/subtractor.
package modaddsub_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_PASS1 = 2'd1;
  localparam state_t ST_PASS2 = 2'd2;
  localparam state_t ST_FIN   = 2'd3;

  // Number of digits per operand; a zero DIGIT is caught by params_ok, so avoid dividing by it here.
  function automatic int unsigned calc_ndig(input int unsigned width, input int unsigned digit);
    return (digit == 0) ? 1 : (width / digit);
  endfunction

  // Digit counter width, never narrower than one bit.
  function automatic int unsigned calc_cnt_w(input int unsigned ndig);
    return (ndig <= 1) ? 1 : int'($clog2(ndig));
  endfunction

  // WIDTH must be a non-zero multiple of DIGIT.
  function automatic bit params_ok(input int unsigned width, input int unsigned digit);
    return (digit != 0) && (width >= digit) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/modaddsub_serial_digit_adder.sv
// DIGIT-bit combinational ripple adder shared by both serial passes.
module digit_adder
  import modaddsub_pkg::*;
#(
  parameter int unsigned DIGIT = 32
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             c_i,
  output logic [DIGIT-1:0] sum_o,
  output logic             c_o
);

  // Bit-by-bit ripple from c_i up through the digit.
  always_comb begin
    logic carry;
    carry = c_i;
    sum_o = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    c_o = carry;
  end

endmodule

// File: rtl/modaddsub_serial.sv
// Digit-serial modular add/subtract: raw pass (a +/- b) then correction pass (r -/+ p).
module modaddsub_serial
  import modaddsub_pkg::*;
#(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DIGIT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             corr
);

  localparam int unsigned NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int unsigned CNT_W = calc_cnt_w(NDIG);

  if (!params_ok(WIDTH, DIGIT)) begin : g_param_err
    $error("modaddsub_serial: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               c1_q, c1_d;
  logic               c2_q, c2_d;
  logic               op_sub_q, op_sub_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [WIDTH-1:0]   u_q, u_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               corr_q, corr_d;

  logic [DIGIT-1:0]   add_a, add_b, add_sum;
  logic               add_co;
  logic               last_dig;
  logic               sel;

  // Drop the consumed LS digit.
  function automatic logic [WIDTH-1:0] shr(input logic [WIDTH-1:0] x);
    return x >> DIGIT;
  endfunction

  // Drop the LS digit and insert a new digit at the MS end.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] x, input logic [DIGIT-1:0] d);
    return (x >> DIGIT) | (WIDTH'(d) << (WIDTH - DIGIT));
  endfunction

  // Rotate right by one digit; NDIG rotations restore the original value.
  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x);
    return (x >> DIGIT) | (x << (WIDTH - DIGIT));
  endfunction

  assign last_dig = (cnt_q == CNT_W'(NDIG - 1));

  // Operand mux in front of the shared carry chain.
  always_comb begin
    add_a = a_q[DIGIT-1:0];
    add_b = b_q[DIGIT-1:0] ^ {DIGIT{op_sub_q}};
    if (state_q == ST_PASS2) begin
      add_a = r_q[DIGIT-1:0];
      add_b = p_q[DIGIT-1:0] ^ {DIGIT{~op_sub_q}};
    end
  end

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .a_i   (add_a),
    .b_i   (add_b),
    .c_i   (carry_q),
    .sum_o (add_sum),
    .c_o   (add_co)
  );

  // Next-state, datapath and output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    c1_d     = c1_q;
    c2_d     = c2_q;
    op_sub_d = op_sub_q;
    a_d      = a_q;
    b_d      = b_q;
    p_d      = p_q;
    r_d      = r_q;
    u_d      = u_q;
    done_d   = 1'b0;
    res_d    = res_q;
    corr_d   = corr_q;
    sel      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          p_d      = p;
          op_sub_d = op_sub;
          carry_d  = op_sub;
          cnt_d    = '0;
          state_d  = ST_PASS1;
        end
      end
      ST_PASS1: begin
        a_d     = shr(a_q);
        b_d     = shr(b_q);
        r_d     = shift_in(r_q, add_sum);
        carry_d = add_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_dig) begin
          c1_d    = add_co;
          carry_d = ~op_sub_q;
          cnt_d   = '0;
          state_d = ST_PASS2;
        end
      end
      ST_PASS2: begin
        p_d     = shr(p_q);
        r_d     = rotr(r_q);
        u_d     = shift_in(u_q, add_sum);
        carry_d = add_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_dig) begin
          c2_d    = add_co;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_FIN;
        end
      end
      default: begin
        sel     = op_sub_q ? ~c1_q : (c1_q | c2_q);
        res_d   = sel ? u_q : r_q;
        corr_d  = sel;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_PASS1) || (state_d == ST_PASS2);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      c1_q     <= 1'b0;
      c2_q     <= 1'b0;
      op_sub_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      r_q      <= '0;
      u_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= '0;
      corr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      c1_q     <= c1_d;
      c2_q     <= c2_d;
      op_sub_q <= op_sub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p_q      <= p_d;
      r_q      <= r_d;
      u_q      <= u_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      res_q    <= res_d;
      corr_q   <= corr_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign res  = res_q;
  assign corr = corr_q;

endmodule

// File: tb/tb_modaddsub_serial.sv
// Scoreboard bench for modaddsub_serial at WIDTH=16, DIGIT=4.
module tb_modaddsub_serial;

  localparam int unsigned W    = 16;
  localparam int unsigned D    = 4;
  localparam int unsigned NDIG = W / D;
  localparam int          LAT  = 2 * NDIG + 1;
  localparam logic [W-1:0] P0  = 16'hFFF1;

  typedef struct {
    logic [W-1:0] e_res;
    logic         e_corr;
    int           e_start;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, start, op_sub;
  logic [W-1:0] a, b, p;
  logic         busy, done, corr;
  logic [W-1:0] res;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  modaddsub_serial #(.WIDTH(W), .DIGIT(D)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_sub (op_sub),
    .a      (a),
    .b      (b),
    .p      (p),
    .busy   (busy),
    .done   (done),
    .res    (res),
    .corr   (corr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference: plain modular arithmetic; corr marks that p was added or removed.
  function automatic void ref_model(input int unsigned ia, input int unsigned ib, input int unsigned ip,
                                    input bit iop, output logic [W-1:0] r, output logic c);
    int unsigned s;
    if (!iop) begin
      s = ia + ib;
      c = (s >= ip);
      r = W'(c ? s - ip : s);
    end else begin
      c = (ia < ib);
      r = W'(c ? ia + ip - ib : ia - ib);
    end
  endfunction

  // Monitor: every cycle compare busy/done timing, and res/corr on done.
  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_done, exp_busy;
      exp_done = (exp_q.size() != 0) && (cyc == exp_q[0].e_start + LAT);
      exp_busy = (exp_q.size() != 0) && (cyc >= exp_q[0].e_start) &&
                 (cyc < exp_q[0].e_start + 2 * int'(NDIG));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      if (exp_done) begin
        if (done === 1'b1) begin
          chk("res", 32'(res), 32'(exp_q[0].e_res));
          chk("corr", 32'(corr), 32'(exp_q[0].e_corr));
        end
        void'(exp_q.pop_front());
      end
    end
  end

  // Wait for the previous op to drain, then issue one op and scramble inputs while busy.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] ip,
                       input logic iop, input logic [W-1:0] er, input logic ec);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (exp_q.size() != 0 && n < 4 * LAT) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("idle_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    a = ia; b = ib; p = ip; op_sub = iop; start = 1'b1;
    exp_q.push_back('{e_res: er, e_corr: ec, e_start: cyc + 1});
    @(posedge clk); #1;
    start  = 1'b0;
    a      = W'($urandom);
    b      = W'($urandom);
    p      = W'($urandom);
    op_sub = 1'($urandom);
  endtask

  task automatic issue_model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] ip,
                             input logic iop);
    logic [W-1:0] er;
    logic         ec;
    ref_model(32'(ia), 32'(ib), 32'(ip), iop, er, ec);
    issue(ia, ib, ip, iop, er, ec);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op_sub = 1'b0;
    a = '0; b = '0; p = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_res", 32'(res), 32'd0);
    chk("reset_corr", 32'(corr), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Directed cases with p = 0xFFF1.
    issue(16'h0001, 16'h0002, P0, 1'b0, 16'h0003, 1'b0);
    issue(16'hFFF0, 16'hFFF0, P0, 1'b0, 16'hFFEF, 1'b1);
    issue(16'hFFF0, 16'h0002, P0, 1'b0, 16'h0001, 1'b1);
    issue(16'h0001, 16'h0002, P0, 1'b1, 16'hFFF0, 1'b1);
    issue(16'h0005, 16'h0005, P0, 1'b1, 16'h0000, 1'b0);

    // Start pulsed during busy must be ignored.
    issue(16'h1234, 16'h0100, P0, 1'b0, 16'h1334, 1'b0);
    @(posedge clk); #1;
    a = 16'h0F00; b = 16'h0F00; op_sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    // Back-to-back op right after done.
    issue_model(16'h0100, 16'h0200, P0, 1'b1);

    // Reset in the first PASS2 cycle aborts with no done.
    issue(16'h0010, 16'h0020, P0, 1'b0, 16'h0030, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_res", 32'(res), 32'd0);
    chk("abort_corr", 32'(corr), 32'd0);
    repeat (LAT + 2) @(posedge clk);
    #1;

    // Start together with reset: reset wins.
    rst = 1'b1; start = 1'b1; a = 16'h0001; b = 16'h0001; p = P0; op_sub = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);

    issue(16'h0005, 16'h0005, P0, 1'b0, 16'h000A, 1'b0);

    // Random operands below a random modulus, both operations.
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] rp, ra, rb;
      rp = (i % 4 == 0) ? P0 : W'($urandom_range(2, 32'hFFFF));
      ra = W'($urandom_range(0, 32'(rp) - 1));
      rb = W'($urandom_range(0, 32'(rp) - 1));
      issue_model(ra, rb, rp, 1'($urandom));
    end

    repeat (LAT + 4) @(posedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
